// File: rtl/key_conditioner_if.sv
// Key bundle between the board buttons and the conditioner.
// The master drives raw keys; the slave returns the conditioned levels and events.
interface key_conditioner_if #(
  parameter int unsigned N_KEYS = 4
);
  logic [N_KEYS-1:0] KEY;
  logic [N_KEYS-1:0] KEY_STATE;
  logic [N_KEYS-1:0] KEY_PRESS;
  logic [N_KEYS-1:0] KEY_RELEASE;
  logic [N_KEYS-1:0] KEY_REPEAT;
  logic              ANY_HELD;

  modport master (
    output KEY,
    input  KEY_STATE, KEY_PRESS, KEY_RELEASE, KEY_REPEAT, ANY_HELD
  );

  modport slave (
    input  KEY,
    output KEY_STATE, KEY_PRESS, KEY_RELEASE, KEY_REPEAT, ANY_HELD
  );
endinterface

// File: rtl/key_conditioner.sv
// Push-button conditioner: per key it synchronises, debounces, and emits press,
// release and auto-repeat pulses. Channels are fully independent.
module key_conditioner #(
  parameter int unsigned N_KEYS     = 4,
  parameter int unsigned DEB_CYCLES = 10,
  parameter int unsigned REP_DELAY  = 250,
  parameter int unsigned REP_RATE   = 50,
  parameter int unsigned CW         = 9
) (
  input  logic             CLK_500Hz,
  input  logic             RESET_N,
  key_conditioner_if.slave keys
);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REP_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REP_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;

  logic [N_KEYS-1:0] state_v;
  logic [N_KEYS-1:0] press_v;
  logic [N_KEYS-1:0] release_v;
  logic [N_KEYS-1:0] repeat_v;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic          sync1, sync2;
    logic          state_q, press_q, release_q, repeat_q;
    logic [CW-1:0] dc, rc;
    rep_state_e    rep_state;
    logic          s, toggle, pressed, released;

    // Sync flops hold the raw (active-low) level, so s is the pressed sense.
    assign s        = ~sync2;
    assign toggle   = (s != state_q) && (dc == DEB_LAST);
    assign pressed  = toggle && !state_q;
    assign released = toggle && state_q;

    always_ff @(posedge CLK_500Hz) begin
      if (!RESET_N) begin
        sync1     <= 1'b1;
        sync2     <= 1'b1;
        state_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
        dc        <= '0;
        rc        <= '0;
        rep_state <= IDLE;
      end else begin
        sync1     <= keys.KEY[k];
        sync2     <= sync1;
        press_q   <= pressed;
        release_q <= released;
        repeat_q  <= 1'b0;

        if (s == state_q) begin
          dc <= '0;
        end else if (toggle) begin
          dc      <= '0;
          state_q <= ~state_q;
        end else begin
          dc <= dc + CW'(1);
        end

        // Release always wins over a coinciding repeat tick.
        case (rep_state)
          IDLE: begin
            if (pressed) begin
              repeat_q  <= 1'b1;
              rc        <= '0;
              rep_state <= DELAY;
            end
          end
          DELAY: begin
            if (released) begin
              rc        <= '0;
              rep_state <= IDLE;
            end else if (rc == DELAY_LAST) begin
              repeat_q  <= 1'b1;
              rc        <= '0;
              rep_state <= REPEAT;
            end else begin
              rc <= rc + CW'(1);
            end
          end
          REPEAT: begin
            if (released) begin
              rc        <= '0;
              rep_state <= IDLE;
            end else if (rc == RATE_LAST) begin
              repeat_q <= 1'b1;
              rc       <= '0;
            end else begin
              rc <= rc + CW'(1);
            end
          end
          default: begin
            rc        <= '0;
            rep_state <= IDLE;
          end
        endcase
      end
    end

    assign state_v[k]   = state_q;
    assign press_v[k]   = press_q;
    assign release_v[k] = release_q;
    assign repeat_v[k]  = repeat_q;
  end

  assign keys.KEY_STATE   = state_v;
  assign keys.KEY_PRESS   = press_v;
  assign keys.KEY_RELEASE = release_v;
  assign keys.KEY_REPEAT  = repeat_v;
  assign keys.ANY_HELD    = |state_v;
endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random key activity, all
// checked every cycle against a sample-window / hold-time reference model.
module tb_key_conditioner;
  localparam int unsigned NK  = 4;
  localparam int unsigned DEB = 10;
  localparam int unsigned RD  = 250;
  localparam int unsigned RR  = 50;

  logic clk = 1'b0;
  logic rst_n;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  key_conditioner_if #(.N_KEYS(NK)) kif ();

  key_conditioner #(
    .N_KEYS(NK), .DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_RATE(RR), .CW(9)
  ) dut (
    .CLK_500Hz(clk),
    .RESET_N  (rst_n),
    .keys     (kif)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a key flips once its last DEB sampled levels all disagree
  // with the debounced level; repeats are timed from the hold age since press.
  logic [NK-1:0]  m_sync1, m_sync2, m_state, m_press, m_release, m_repeat;
  logic [DEB-1:0] m_win [NK];
  int             m_valid [NK];
  int             m_age [NK];

  function automatic logic repeat_due(input int age);
    return (age == RD) || (age > RD && ((age - RD) % RR) == 0);
  endfunction

  task automatic model_step();
    logic [NK-1:0] s;
    logic          tog;
    if (!rst_n) begin
      m_sync1 = '1; m_sync2 = '1;
      m_state = '0; m_press = '0; m_release = '0; m_repeat = '0;
      for (int k = 0; k < NK; k++) begin
        m_win[k] = '0; m_valid[k] = 0; m_age[k] = 0;
      end
    end else begin
      s = ~m_sync2;
      m_sync2 = m_sync1;
      m_sync1 = kif.KEY;
      for (int k = 0; k < NK; k++) begin
        m_win[k] = {m_win[k][DEB-2:0], s[k]};
        if (m_valid[k] < DEB) m_valid[k]++;
        tog = (m_valid[k] >= DEB) && (m_win[k] == {DEB{~m_state[k]}});
        m_press[k]   = tog && !m_state[k];
        m_release[k] = tog && m_state[k];
        if (tog) m_state[k] = ~m_state[k];
        m_repeat[k] = 1'b0;
        if (m_press[k]) begin
          m_age[k] = 0;
          m_repeat[k] = 1'b1;
        end else if (m_state[k]) begin
          m_age[k]++;
          m_repeat[k] = repeat_due(m_age[k]);
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("state",   32'(kif.KEY_STATE),   32'(m_state));
      check("press",   32'(kif.KEY_PRESS),   32'(m_press));
      check("release", 32'(kif.KEY_RELEASE), 32'(m_release));
      check("repeat",  32'(kif.KEY_REPEAT),  32'(m_repeat));
      check("any_held", 32'(kif.ANY_HELD),   32'(|m_state));
      check("press_rel_excl", 32'(kif.KEY_PRESS & kif.KEY_RELEASE), 32'(0));
    end
  end

  int hold [NK];
  int cnt_a, cnt_b;

  initial begin
    rst_n  = 1'b0;
    kif.KEY = '1;
    @(negedge clk);
    chk_en = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(100);
    check("t1_idle_outputs", 32'({kif.KEY_STATE, kif.KEY_PRESS, kif.KEY_RELEASE, kif.KEY_REPEAT}), 32'(0));

    // Clean press on key 0: accepted on edge 12.
    kif.KEY[0] = 1'b0;
    step(11);
    check("t2_early", 32'(kif.KEY_STATE[0]), 32'(0));
    step(1);
    check("t2_press",  32'(kif.KEY_PRESS[0]),  32'(1));
    check("t2_repeat", 32'(kif.KEY_REPEAT[0]), 32'(1));
    check("t2_any",    32'(kif.ANY_HELD),      32'(1));
    step(1);
    check("t2_pulse_1cyc", 32'(kif.KEY_PRESS[0]), 32'(0));
    kif.KEY[0] = 1'b1;
    step(30);

    // Bouncing key 1, toggling every 3 cycles, then settling pressed.
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      kif.KEY[1] = i[0];
      for (int j = 0; j < 3; j++) begin
        step(1);
        cnt_a += 32'(kif.KEY_PRESS[1]);
      end
    end
    kif.KEY[1] = 1'b0;
    for (int j = 0; j < 11; j++) begin
      step(1);
      cnt_a += 32'(kif.KEY_PRESS[1]);
    end
    check("t3_no_bounce_press", 32'(cnt_a), 32'(0));
    step(1);
    check("t3_press_after_settle", 32'(kif.KEY_PRESS[1]), 32'(1));
    kif.KEY[1] = 1'b1;
    step(30);

    // Key 2 held 1000 cycles: repeats at press, +RD, then every RR.
    kif.KEY[2] = 1'b0;
    cnt_a = 0; cnt_b = 0;
    for (int c = 1; c <= 1100; c++) begin
      step(1);
      cnt_a += 32'(kif.KEY_REPEAT[2]);
      cnt_b += 32'(kif.KEY_RELEASE[2]);
      if (c == 1000) kif.KEY[2] = 1'b1;
    end
    check("t4_repeat_count",  32'(cnt_a), 32'(1 + (1000 - 1 - RD) / RR + 1));
    check("t4_release_count", 32'(cnt_b), 32'(1));

    // Debounced release of key 0 lands exactly on a repeat tick (press + 300).
    kif.KEY[0] = 1'b0;
    step(12);
    check("t5_press", 32'(kif.KEY_PRESS[0]), 32'(1));
    step(288);
    kif.KEY[0] = 1'b1;
    step(12);
    check("t5_release",   32'(kif.KEY_RELEASE[0]), 32'(1));
    check("t5_no_repeat", 32'(kif.KEY_REPEAT[0]),  32'(0));
    cnt_a = 0;
    for (int c = 0; c < 400; c++) begin
      step(1);
      cnt_a += 32'(kif.KEY_REPEAT[0]);
    end
    check("t5_fsm_idle", 32'(cnt_a), 32'(0));

    // Keys 0 and 3 together, then a one-cycle reset while held.
    kif.KEY[0] = 1'b0;
    kif.KEY[3] = 1'b0;
    step(12);
    check("t6_press_both",  32'(kif.KEY_PRESS),  32'(4'b1001));
    check("t6_repeat_both", 32'(kif.KEY_REPEAT), 32'(4'b1001));
    step(100);
    rst_n = 1'b0;
    step(1);
    check("t6_reset_clear", 32'({kif.KEY_STATE, kif.ANY_HELD}), 32'(0));
    rst_n = 1'b1;
    step(11);
    check("t6_not_yet", 32'(kif.KEY_STATE), 32'(0));
    step(1);
    check("t6_repress", 32'(kif.KEY_PRESS),  32'(4'b1001));
    check("t6_rerep",   32'(kif.KEY_REPEAT), 32'(4'b1001));
    kif.KEY = '1;
    step(30);

    // Random activity: mostly long holds, some sub-debounce glitches, rare resets.
    for (int k = 0; k < NK; k++) hold[k] = 0;
    for (int c = 0; c < 6000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (hold[k] == 0) begin
          kif.KEY[k] = ~kif.KEY[k];
          if ($urandom_range(0, 3) == 0) hold[k] = int'($urandom_range(1, DEB));
          else hold[k] = int'($urandom_range(DEB, 450));
        end else begin
          hold[k]--;
        end
      end
      rst_n = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
      step(1);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
